// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// flush-to-bubble and a saturating bubble counter. Optional skid entry: PIPE_STAGE_SKID_EN.
module pipe_stage_reg #(
    parameter int              INSTR_W   = 32,
    parameter int              PC_W      = 32,
    parameter int              PAYLOAD_W = 97,
    parameter logic [PC_W-1:0] PC_RST    = '0,
    parameter bit              KEEP_PC   = 1'b1,
    parameter int              CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   instr_in,
    input  logic [PC_W-1:0]      pc_in,
    input  logic [PAYLOAD_W-1:0] payload_in,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_W-1:0]   instr_out,
    output logic [PC_W-1:0]      pc_out,
    output logic [PAYLOAD_W-1:0] payload_out,
    output logic [CNT_W-1:0]     bubble_cnt
);

    logic                 vld_q, vld_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [PAYLOAD_W-1:0] pay_q, pay_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 in_xfer, out_xfer;

`ifdef PIPE_STAGE_SKID_EN
    logic                 rdy_q, rdy_d;
    logic                 skid_vld_q, skid_vld_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
    logic [PAYLOAD_W-1:0] skid_pay_q, skid_pay_d;

    // Registered ready; flush only gates it, out_ready never reaches it.
    assign in_ready = rdy_q && !flush;
`else
    assign in_ready = (!vld_q || out_ready) && !flush;
`endif

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = vld_q && out_ready && !flush;

    always_comb begin
        vld_d   = vld_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pay_d   = pay_q;
        cnt_d   = (!vld_q && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_pay_d   = skid_pay_q;
        if (flush) begin
            vld_d      = 1'b0;
            instr_d    = '0;
            pay_d      = '0;
            pc_d       = KEEP_PC ? pc_q : '0;
            skid_vld_d = 1'b0;
        end else if (out_xfer) begin
            if (skid_vld_q) begin
                vld_d      = 1'b1;
                instr_d    = skid_instr_q;
                pc_d       = skid_pc_q;
                pay_d      = skid_pay_q;
                skid_vld_d = in_xfer;
                if (in_xfer) begin
                    skid_instr_d = instr_in;
                    skid_pc_d    = pc_in;
                    skid_pay_d   = payload_in;
                end
            end else if (in_xfer) begin
                instr_d = instr_in;
                pc_d    = pc_in;
                pay_d   = payload_in;
            end else begin
                vld_d   = 1'b0;
                instr_d = '0;
                pay_d   = '0;
            end
        end else if (in_xfer) begin
            // Output is stalled with a held beat: park the new one in the skid.
            if (vld_q) begin
                skid_vld_d   = 1'b1;
                skid_instr_d = instr_in;
                skid_pc_d    = pc_in;
                skid_pay_d   = payload_in;
            end else begin
                vld_d   = 1'b1;
                instr_d = instr_in;
                pc_d    = pc_in;
                pay_d   = payload_in;
            end
        end
        rdy_d = !skid_vld_d;
`else
        if (flush) begin
            vld_d   = 1'b0;
            instr_d = '0;
            pay_d   = '0;
            pc_d    = KEEP_PC ? pc_q : '0;
        end else if (in_xfer) begin
            vld_d   = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
            pay_d   = payload_in;
        end else if (out_xfer) begin
            // Bubble keeps the last PC visible for EPC capture.
            vld_d   = 1'b0;
            instr_d = '0;
            pay_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q   <= 1'b0;
            instr_q <= '0;
            pc_q    <= PC_RST;
            pay_q   <= '0;
            cnt_q   <= '0;
`ifdef PIPE_STAGE_SKID_EN
            rdy_q        <= 1'b0;
            skid_vld_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_pay_q   <= '0;
`endif
        end else begin
            vld_q   <= vld_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pay_q   <= pay_d;
            cnt_q   <= cnt_d;
`ifdef PIPE_STAGE_SKID_EN
            rdy_q        <= rdy_d;
            skid_vld_q   <= skid_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_pay_q   <= skid_pay_d;
`endif
        end
    end

    assign out_valid   = vld_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
    assign payload_out = pay_q;
    assign bubble_cnt  = cnt_q;

endmodule
